// File: rtl/dac_fmt_ddr.sv
// DAC output formatter: per-channel saturating offset, mode override (normal/mute/ramp/hold),
// offset-binary/two's-complement conversion, and registered phase-A/B words for a DDR output primitive.
module dac_fmt_ddr #(
    parameter int NUM_DAC = 2,
    parameter int DW      = 16,
    parameter int RAMP_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DAC*2*DW-1:0]   din,
    input  logic                      din_valid,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_addr,
    input  logic [DW-1:0]             cfg_data,
    output logic [NUM_DAC*DW-1:0]     dac_a,
    output logic [NUM_DAC*DW-1:0]     dac_b,
    output logic [15:0]               underrun_cnt,
    output logic                      busy_mute
);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_MUTE   = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {a[DW-1], a} + {b[DW-1], b};
        if (sum[DW] != sum[DW-1])
            sat_add = sum[DW] ? MSB : ~MSB;
        else
            sat_add = sum[DW-1:0];
    endfunction

    mode_t              mode_q, mode_d;
    logic               fmt_q, fmt_d;
    logic               fmt_s1_q, fmt_s1_d;
    logic [RAMP_W-1:0]  step_q, step_d;
    logic [DW-1:0]      r_q, r_d;
    logic               ramp_act_q, ramp_act_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               cfg_ctl_we;
    logic               cnt_clr;
    logic [DW-1:0]      step_ext;
    logic [DW-1:0]      ramp_base;
    logic [DW-1:0]      ramp_a;
    logic [DW-1:0]      ramp_b;

    assign cfg_ctl_we = cfg_we && (cfg_addr == 4'd8);
    assign cnt_clr    = cfg_ctl_we && cfg_data[3];
    assign step_ext   = DW'(step_q);

    // The ramp restarts from zero whenever it was not running on the previous sample.
    assign ramp_base  = ramp_act_q ? r_q : '0;
    assign ramp_a     = ramp_base;
    assign ramp_b     = ramp_base + step_ext;

    always_comb begin
        mode_d     = mode_q;
        fmt_d      = fmt_q;
        step_d     = step_q;
        if (cfg_ctl_we) begin
            mode_d = mode_t'(cfg_data[1:0]);
            fmt_d  = cfg_data[2];
        end
        if (cfg_we && (cfg_addr == 4'd9))
            step_d = cfg_data[RAMP_W-1:0];

        fmt_s1_d   = fmt_q;
        ramp_act_d = (mode_q == MODE_RAMP);
        r_d        = (mode_q == MODE_RAMP) ? (ramp_base + (step_ext << 1)) : r_q;
        busy_d     = (mode_d != MODE_NORMAL);

        cnt_d      = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if ((mode_q == MODE_NORMAL) && !din_valid && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_MUTE;
            fmt_q      <= 1'b0;
            fmt_s1_q   <= 1'b0;
            step_q     <= RAMP_W'(1);
            r_q        <= '0;
            ramp_act_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            fmt_q      <= fmt_d;
            fmt_s1_q   <= fmt_s1_d;
            step_q     <= step_d;
            r_q        <= r_d;
            ramp_act_q <= ramp_act_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign underrun_cnt = cnt_q;
    assign busy_mute    = busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DAC; gi++) begin : g_ch
            logic [DW-1:0] off_q, off_d;
            logic [DW-1:0] sa_q, sa_d;
            logic [DW-1:0] sb_q, sb_d;
            logic [DW-1:0] oa_q, oa_d;
            logic [DW-1:0] ob_q, ob_d;
            logic [DW-1:0] din_a;
            logic [DW-1:0] din_b;

            assign din_a = din[(2*gi)*DW +: DW];
            assign din_b = din[(2*gi+1)*DW +: DW];

            always_comb begin
                off_d = off_q;
                if (cfg_we && (cfg_addr == 4'(gi)))
                    off_d = cfg_data;

                sa_d = sa_q;
                sb_d = sb_q;
                case (mode_q)
                    MODE_NORMAL: begin
                        if (din_valid) begin
                            sa_d = sat_add(din_a, off_q);
                            sb_d = sat_add(din_b, off_q);
                        end
                    end
                    MODE_MUTE: begin
                        sa_d = '0;
                        sb_d = '0;
                    end
                    MODE_RAMP: begin
                        sa_d = ramp_a;
                        sb_d = ramp_b;
                    end
                    default: ;
                endcase

                oa_d = fmt_s1_q ? sa_q : (sa_q ^ MSB);
                ob_d = fmt_s1_q ? sb_q : (sb_q ^ MSB);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    off_q <= '0;
                    sa_q  <= '0;
                    sb_q  <= '0;
                    oa_q  <= MSB;
                    ob_q  <= MSB;
                end else begin
                    off_q <= off_d;
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    oa_q  <= oa_d;
                    ob_q  <= ob_d;
                end
            end

            assign dac_a[gi*DW +: DW] = oa_q;
            assign dac_b[gi*DW +: DW] = ob_q;
        end
    endgenerate

endmodule

// File: tb/tb_dac_fmt_ddr.sv
// Directed testbench for dac_fmt_ddr: 2 channels, 16-bit words, hand-computed expectations.
module tb_dac_fmt_ddr;

    localparam int NUM_DAC = 2;
    localparam int DW      = 16;
    localparam int RAMP_W  = 16;

    logic                    clk;
    logic                    rst;
    logic [NUM_DAC*2*DW-1:0] din;
    logic                    din_valid;
    logic                    cfg_we;
    logic [3:0]              cfg_addr;
    logic [DW-1:0]           cfg_data;
    logic [NUM_DAC*DW-1:0]   dac_a;
    logic [NUM_DAC*DW-1:0]   dac_b;
    logic [15:0]             underrun_cnt;
    logic                    busy_mute;

    int checks = 0;
    int errors = 0;

    dac_fmt_ddr #(.NUM_DAC(NUM_DAC), .DW(DW), .RAMP_W(RAMP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .dac_a        (dac_a),
        .dac_b        (dac_b),
        .underrun_cnt (underrun_cnt),
        .busy_mute    (busy_mute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [DW-1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
    endtask

    task automatic set_din(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
        din[(2*ch)*DW +: DW]   = a;
        din[(2*ch+1)*DW +: DW] = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; din = '0; din_valid = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        #12;
        checks++;
        if (dac_a !== 32'h8000_8000 || dac_b !== 32'h8000_8000) begin
            errors++;
            $display("FAIL reset_mid: dac_a=%h dac_b=%h expected 80008000", dac_a, dac_b);
        end
        checks++;
        if (underrun_cnt !== 16'd0 || busy_mute !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: cnt=%0d busy=%b expected 0/1", underrun_cnt, busy_mute);
        end
        @(posedge clk); #1; rst = 1'b1;
        steps(3);
        checks++;
        if (dac_a !== 32'h8000_8000 || dac_b !== 32'h8000_8000) begin
            errors++;
            $display("FAIL reset_mute: dac_a=%h dac_b=%h expected 80008000", dac_a, dac_b);
        end
        $display("test_reset done: dac_a=%h dac_b=%h", dac_a, dac_b);
    endtask

    task automatic test_basic();
        din_valid = 1'b1;
        set_din(0, 16'h0000, 16'hFFFF);
        set_din(1, 16'h1111, 16'hEEEE);
        cfg_write(4'd8, 16'h0000);
        checks++;
        if (busy_mute !== 1'b0) begin
            errors++;
            $display("FAIL busy_normal: busy=%b expected 0", busy_mute);
        end
        steps(2);
        checks++;
        if (dac_a[15:0] !== 16'h8000 || dac_b[15:0] !== 16'h7FFF) begin
            errors++;
            $display("FAIL basic_ch0: a=%h b=%h expected 8000/7fff", dac_a[15:0], dac_b[15:0]);
        end
        checks++;
        if (dac_a[31:16] !== 16'h9111 || dac_b[31:16] !== 16'h6EEE) begin
            errors++;
            $display("FAIL basic_ch1: a=%h b=%h expected 9111/6eee", dac_a[31:16], dac_b[31:16]);
        end
        $display("test_basic done: dac_a=%h dac_b=%h", dac_a, dac_b);
    endtask

    task automatic test_saturation();
        cfg_write(4'd1, 16'h7000);
        set_din(1, 16'h2000, 16'h0100);
        steps(2);
        checks++;
        if (dac_a[31:16] !== 16'hFFFF || dac_b[31:16] !== 16'hF100) begin
            errors++;
            $display("FAIL sat_pos: a=%h b=%h expected ffff/f100", dac_a[31:16], dac_b[31:16]);
        end
        cfg_write(4'd1, 16'h9000);
        set_din(1, 16'hE000, 16'hFF00);
        steps(2);
        checks++;
        if (dac_a[31:16] !== 16'h0000 || dac_b[31:16] !== 16'h0F00) begin
            errors++;
            $display("FAIL sat_neg: a=%h b=%h expected 0000/0f00", dac_a[31:16], dac_b[31:16]);
        end
        checks++;
        if (dac_a[15:0] !== 16'h8000) begin
            errors++;
            $display("FAIL sat_ch0_isolated: a=%h expected 8000", dac_a[15:0]);
        end
        cfg_write(4'd1, 16'h0000);
        $display("test_saturation done: dac_a=%h dac_b=%h", dac_a, dac_b);
    endtask

    task automatic test_fmt();
        set_din(0, 16'h1234, 16'h0000);
        cfg_write(4'd8, 16'h0004);
        steps(2);
        checks++;
        if (dac_a[15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL fmt_twos: a=%h expected 1234", dac_a[15:0]);
        end
        cfg_write(4'd8, 16'h0000);
        step();
        checks++;
        if (dac_a[15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL fmt_latency: a=%h expected 1234 two clk after write", dac_a[15:0]);
        end
        step();
        checks++;
        if (dac_a[15:0] !== 16'h9234) begin
            errors++;
            $display("FAIL fmt_offbin: a=%h expected 9234", dac_a[15:0]);
        end
        $display("test_fmt done: dac_a=%h", dac_a);
    endtask

    task automatic test_ramp();
        logic [15:0] exp_a [3];
        logic [15:0] exp_b [3];
        exp_a[0] = 16'd0;  exp_b[0] = 16'd3;
        exp_a[1] = 16'd6;  exp_b[1] = 16'd9;
        exp_a[2] = 16'd12; exp_b[2] = 16'd15;
        cfg_write(4'd8, 16'h0001);
        cfg_write(4'd9, 16'd3);
        cfg_write(4'd8, 16'h0006);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            for (int c = 0; c < NUM_DAC; c++) begin
                checks++;
                if (dac_a[c*DW +: DW] !== exp_a[k] || dac_b[c*DW +: DW] !== exp_b[k]) begin
                    errors++;
                    $display("FAIL ramp_step3 k=%0d ch=%0d: a=%h b=%h expected %h/%h",
                             k, c, dac_a[c*DW +: DW], dac_b[c*DW +: DW], exp_a[k], exp_b[k]);
                end
            end
            $display("ramp pair %0d: dac_a=%h dac_b=%h", k, dac_a, dac_b);
        end
        checks++;
        if (busy_mute !== 1'b1) begin
            errors++;
            $display("FAIL busy_ramp: busy=%b expected 1", busy_mute);
        end
        cfg_write(4'd8, 16'h0005);
        cfg_write(4'd9, 16'h8000);
        cfg_write(4'd8, 16'h0006);
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (dac_a !== 32'h0000_0000 || dac_b !== 32'h8000_8000) begin
                errors++;
                $display("FAIL ramp_wrap k=%0d: a=%h b=%h expected 00000000/80008000", k, dac_a, dac_b);
            end
        end
        cfg_write(4'd9, 16'd1);
        $display("test_ramp done");
    endtask

    task automatic test_hold();
        set_din(0, 16'h0555, 16'h0666);
        cfg_write(4'd8, 16'h0004);
        steps(2);
        cfg_write(4'd8, 16'h0007);
        set_din(0, 16'h0AAA, 16'h0BBB);
        steps(3);
        checks++;
        if (dac_a[15:0] !== 16'h0555 || dac_b[15:0] !== 16'h0666) begin
            errors++;
            $display("FAIL hold_freeze: a=%h b=%h expected 0555/0666", dac_a[15:0], dac_b[15:0]);
        end
        $display("test_hold done: dac_a=%h dac_b=%h", dac_a, dac_b);
    endtask

    task automatic test_underrun();
        set_din(0, 16'h0100, 16'h0200);
        cfg_write(4'd8, 16'h0008);
        checks++;
        if (underrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL underrun_clear_init: cnt=%0d expected 0", underrun_cnt);
        end
        steps(2);
        din_valid = 1'b0;
        set_din(0, 16'h7777, 16'h7777);
        steps(5);
        checks++;
        if (underrun_cnt !== 16'd5) begin
            errors++;
            $display("FAIL underrun_count: cnt=%0d expected 5", underrun_cnt);
        end
        checks++;
        if (dac_a[15:0] !== 16'h8100 || dac_b[15:0] !== 16'h8200) begin
            errors++;
            $display("FAIL underrun_hold: a=%h b=%h expected 8100/8200", dac_a[15:0], dac_b[15:0]);
        end
        cfg_write(4'd8, 16'h0008);
        checks++;
        if (underrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL underrun_clear_wins: cnt=%0d expected 0", underrun_cnt);
        end
        step();
        checks++;
        if (underrun_cnt !== 16'd1) begin
            errors++;
            $display("FAIL underrun_resume: cnt=%0d expected 1", underrun_cnt);
        end
        $display("test_underrun done: cnt=%0d", underrun_cnt);
    endtask

    task automatic test_async_reset();
        din_valid = 1'b1;
        set_din(0, 16'h0100, 16'h0200);
        steps(2);
        din_valid = 1'b0;
        steps(2);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dac_a !== 32'h8000_8000 || dac_b !== 32'h8000_8000) begin
            errors++;
            $display("FAIL async_reset_out: a=%h b=%h expected 80008000", dac_a, dac_b);
        end
        checks++;
        if (busy_mute !== 1'b1 || underrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_status: busy=%b cnt=%0d expected 1/0", busy_mute, underrun_cnt);
        end
        din_valid = 1'b1;
        steps(2);
        rst = 1'b1;
        steps(3);
        checks++;
        if (dac_a !== 32'h8000_8000 || dac_b !== 32'h8000_8000) begin
            errors++;
            $display("FAIL post_reset_mute: a=%h b=%h expected 80008000", dac_a, dac_b);
        end
        cfg_write(4'd8, 16'h0000);
        steps(2);
        checks++;
        if (dac_a[15:0] !== 16'h8100 || dac_b[15:0] !== 16'h8200) begin
            errors++;
            $display("FAIL post_reset_normal: a=%h b=%h expected 8100/8200", dac_a[15:0], dac_b[15:0]);
        end
        $display("test_async_reset done: dac_a=%h dac_b=%h", dac_a, dac_b);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_fmt();
        test_ramp();
        test_hold();
        test_underrun();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_fmt_ddr.md
Name: dac_fmt_ddr

Overview:
- Parametrised DAC output formatter between the NCO/waveform core and the DAC pins.
- Accepts two signed samples per channel per clk (phase A/B), one channel per DAC bus.
- Applies a per-channel saturating offset, mode override (normal/mute/ramp/hold) and output format conversion.
- Registers phase-A/phase-B words for an external DDR output primitive, and counts input underruns.

Parameters:
NUM_DAC, 2, number of DAC buses (channels), 1..8
DW, 16, sample and DAC word width
RAMP_W, 16, width of the test-ramp step register (must be <= DW)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset; assert async, release sync to clk externally
din  in  NUM_DAC*2*DW  signed samples; channel c phase A at [(2c)*DW +: DW], phase B at [(2c+1)*DW +: DW]
din_valid  in  1  din holds a new sample pair for all channels this cycle
cfg_we  in  1  config write strobe, one cycle
cfg_addr  in  4  config address
cfg_data  in  DW  config write data
dac_a  out  NUM_DAC*DW  registered phase-A words, channel c at [c*DW +: DW]
dac_b  out  NUM_DAC*DW  registered phase-B words
underrun_cnt  out  16  saturating count of cycles with din_valid=0 while mode=normal
busy_mute  out  1  1 while any channel output is forced (mode != normal)

Behaviour:
- Reset (rst=0): all pipeline regs cleared. dac_a/dac_b = midscale in the current format, i.e. 1<<(DW-1) for offset binary (fmt reset = offset binary). Config regs: offsets=0, mode=mute, fmt=0, ramp_step=1. underrun_cnt=0. busy_mute=1.
- Config map:
  - addr 0..NUM_DAC-1: signed offset for channel addr.
  - addr 8: bits[1:0] mode (0 normal, 1 mute, 2 ramp, 3 hold); bit[2] fmt (0 offset binary, 1 two's complement); bit[3] clear underrun_cnt.
  - addr 9: ramp_step, low RAMP_W bits.
  - Other addresses are ignored.
  - A write takes effect on the sample entering stage 1 in the next cycle.
  - A clear on the same cycle as an increment wins (count -> 0).
- Stage 1 (cycle 1):
  - normal, din_valid=1: s = din + offset, computed DW+1 wide, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - normal, din_valid=0: the last valid stage-1 value is held (no zero-stuffing).
  - mute: s = 0.
  - hold: s freezes at the value present when hold was entered.
  - ramp: shared counter r (DW bits, wraps modulo 2^DW) with r_B = r + ramp_step and r_next = r + 2*ramp_step. Phase A = r, phase B = r_B, identical on all channels. Offset is not applied. r resets to 0 on entering ramp.
- Stage 2 (cycle 2):
  - fmt=0: out = s XOR (1<<(DW-1)), the offset-binary conversion.
  - fmt=1: out = s.
  - Result is registered into dac_a/dac_b.
- Latency: din to dac_a/dac_b is exactly 2 clk. A config change is visible at the outputs 3 clk after cfg_we.
- Phase ordering: per cycle, phase A is the earlier sample in time, phase B the later one. The external DDR drives A on the high clk phase and B on the low phase.
- underrun_cnt: increments when mode=normal and din_valid=0; saturates at 16'hFFFF with no wrap.
- busy_mute: registered, equals (mode != 0), one cycle after the config write.
- Reset mid-operation:
  - Outputs return to midscale asynchronously.
  - Config returns to defaults, so mode=mute; software must rewrite mode=normal.

Test Plan:
1. Reset then mode=normal, fmt=0; din ch0 A=0, B=-1 -> 2 cycles later dac_a[ch0]=16'h8000, dac_b[ch0]=16'h7FFF.
2. Offset saturation: ch1 offset=16'h7000, din ch1 A=16'h2000 -> dac_a[ch1]=16'hFFFF (7FFF XOR 8000); offset=-16'h7000, din=-16'h2000 -> 16'h0000.
3. fmt=1, ch0 din A=16'h1234 -> dac_a[ch0]=16'h1234 after 2 clk; write fmt=0 -> 16'h9234 from 3 clk after cfg_we.
4. Ramp, step=3 -> successive (A,B) pairs on all channels (0,3), (6,9), …; wrap check step=16'h8000 -> pairs (0,8000),(0,8000) in fmt=1.
5. Underrun: mode=normal, drop din_valid 5 cycles -> outputs hold the last value, underrun_cnt=5; a clear write in the same cycle as a further drop -> 0.
6. Async reset asserted mid-stream with no clk edge -> dac_a/dac_b=16'h8000 immediately, busy_mute=1, underrun_cnt=0; after release the outputs stay midscale until mode=normal is written.
